inst_queue: RTL and testbench

- Circular FIFO between the instruction fetcher and the combinational decoder.
- Buffers fetched instruction/PC pairs and presents the oldest entry to the decoder in show-ahead form.
- Pops an entry when the dispatcher is not stalled.
- Discards all contents on a ROB flush; provides back-pressure to the fetcher.

---
 rtl/inst_queue.sv | 89 ++++++++
 tb/tb_inst_queue.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Show-ahead instruction FIFO between fetcher and decoder, flushed by the ROB.
// Optional macro INST_QUEUE_BYPASS_EN: zero-latency fetch-to-decoder path when the queue is empty.
module inst_queue #(
  parameter int QUEUE_SIZE_LOG2 = 4,
  parameter int INST_W          = 32,
  parameter int ADDR_W          = 32
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic              rdy_in,
  input  logic              rob_flush_in,
  input  logic              fetcher_en_in,
  input  logic [INST_W-1:0] fetcher_inst_in,
  input  logic [ADDR_W-1:0] fetcher_pc_in,
  output logic              fetcher_full_out,
  input  logic              dispatcher_stall_in,
  output logic              decoder_inst_en_out,
  output logic [INST_W-1:0] decoder_inst_out,
  output logic [ADDR_W-1:0] decoder_pc_out
);
  localparam int DEPTH = 1 << QUEUE_SIZE_LOG2;
  localparam logic [QUEUE_SIZE_LOG2:0] FULL_CNT = (QUEUE_SIZE_LOG2+1)'(DEPTH);

  logic [INST_W-1:0]          inst_mem [DEPTH];
  logic [ADDR_W-1:0]          pc_mem   [DEPTH];
  logic [QUEUE_SIZE_LOG2-1:0] head, tail;
  logic [QUEUE_SIZE_LOG2:0]   count;

  logic active, empty, full, pop, push, byp, byp_take;

  assign active = rdy_in & ~rob_flush_in;
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue: forward the fetched word; it is only stored if the decoder stalls.
  assign byp      = empty & fetcher_en_in & active;
  assign byp_take = byp & ~dispatcher_stall_in;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign pop  = active & ~empty & ~dispatcher_stall_in;
  assign push = active & fetcher_en_in & (~full | pop) & ~byp_take;

  assign fetcher_full_out    = full;
  assign decoder_inst_en_out = ~empty | byp;

  always_comb begin
    decoder_inst_out = '0;
    decoder_pc_out   = '0;
    if (!empty) begin
      decoder_inst_out = inst_mem[head];
      decoder_pc_out   = pc_mem[head];
    end else if (byp) begin
      decoder_inst_out = fetcher_inst_in;
      decoder_pc_out   = fetcher_pc_in;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail] <= fetcher_inst_in;
      pc_mem[tail]   <= fetcher_pc_in;
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in && rob_flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (default build, no bypass): vector table plus corner sequences.
module tb_inst_queue;
  logic        clk_in = 1'b0;
  logic        rstn_in, rdy_in, rob_flush_in, fetcher_en_in, dispatcher_stall_in;
  logic [31:0] fetcher_inst_in, fetcher_pc_in;
  logic        fetcher_full_out, decoder_inst_en_out;
  logic [31:0] decoder_inst_out, decoder_pc_out;

  int errors = 0;
  int checks = 0;

  inst_queue dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in), .rob_flush_in(rob_flush_in),
    .fetcher_en_in(fetcher_en_in), .fetcher_inst_in(fetcher_inst_in),
    .fetcher_pc_in(fetcher_pc_in), .fetcher_full_out(fetcher_full_out),
    .dispatcher_stall_in(dispatcher_stall_in), .decoder_inst_en_out(decoder_inst_en_out),
    .decoder_inst_out(decoder_inst_out), .decoder_pc_out(decoder_pc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy, flush, push;
    logic [31:0] inst, pc;
    logic        stall;
    logic        e_en;
    logic [31:0] e_inst, e_pc;
    logic        e_full;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic flush, input logic push,
                       input logic [31:0] inst, input logic [31:0] pc, input logic stall);
    rdy_in = rdy; rob_flush_in = flush; fetcher_en_in = push;
    fetcher_inst_in = inst; fetcher_pc_in = pc; dispatcher_stall_in = stall;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [31:0] inst,
                         input logic [31:0] pc, input logic full);
    chk({tag, ".en"},   64'(decoder_inst_en_out), 64'(en));
    chk({tag, ".inst"}, 64'(decoder_inst_out),    64'(inst));
    chk({tag, ".pc"},   64'(decoder_pc_out),      64'(pc));
    chk({tag, ".full"}, 64'(fetcher_full_out),    64'(full));
  endtask

  initial begin
    // rdy flush push inst pc stall | en inst pc full  (outputs after the edge)
    vecs[0]  = '{1, 0, 1, 32'h00000093, 32'h0,   0, 1, 32'h00000093, 32'h0,   0};
    vecs[1]  = '{1, 0, 1, 32'h00100113, 32'h4,   0, 1, 32'h00100113, 32'h4,   0};
    vecs[2]  = '{1, 0, 0, 32'h0,        32'h0,   0, 0, 32'h0,        32'h0,   0};
    vecs[3]  = '{1, 0, 1, 32'h11111111, 32'h100, 1, 1, 32'h11111111, 32'h100, 0};
    vecs[4]  = '{1, 0, 1, 32'h22222222, 32'h104, 1, 1, 32'h11111111, 32'h100, 0};
    vecs[5]  = '{1, 0, 1, 32'h33333333, 32'h108, 1, 1, 32'h11111111, 32'h100, 0};
    vecs[6]  = '{1, 0, 0, 32'h0,        32'h0,   0, 1, 32'h22222222, 32'h104, 0};
    vecs[7]  = '{0, 1, 1, 32'h44444444, 32'h10c, 0, 1, 32'h22222222, 32'h104, 0};
    vecs[8]  = '{1, 1, 1, 32'h55555555, 32'h110, 0, 0, 32'h0,        32'h0,   0};
    vecs[9]  = '{1, 0, 0, 32'h0,        32'h0,   0, 0, 32'h0,        32'h0,   0};
    vecs[10] = '{1, 0, 1, 32'hdeadbeef, 32'h200, 0, 1, 32'hdeadbeef, 32'h200, 0};
    vecs[11] = '{1, 1, 0, 32'h0,        32'h0,   0, 0, 32'h0,        32'h0,   0};

    rstn_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("reset", 0, 0, 0, 0);
    rstn_in = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rdy, vecs[i].flush, vecs[i].push, vecs[i].inst, vecs[i].pc, vecs[i].stall);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_full);
    end

    // Flush while 5 entries are queued, with a concurrent push
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 32'h7000 + i, 32'h700 + 4*i, 1);
      tick();
    end
    chk_out("fl_pre", 1, 32'h7000, 32'h700, 0);
    drive(1, 1, 1, 32'h7777, 32'h7ff, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk_out("fl_post", 0, 0, 0, 0);
    tick();
    chk_out("fl_idle", 0, 0, 0, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h9000 + i, 32'h900 + 4*i, 1);
      tick();
    end
    chk_out("rst_pre", 1, 32'h9000, 32'h900, 0);
    drive(1, 0, 0, 0, 0, 1);
    #2 rstn_in = 1'b0;
    #1 chk_out("rst_async", 0, 0, 0, 0);
    #2 rstn_in = 1'b1;
    tick();
    chk_out("rst_after", 0, 0, 0, 0);

    // Fill to 16 with stall, then a dropped 17th push
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 32'h1000 + i, 32'(4*i), 1);
      tick();
      if (i == 14) chk("full_at15", 64'(fetcher_full_out), 64'd0);
    end
    chk_out("full16", 1, 32'h1000, 32'h0, 1);
    drive(1, 0, 1, 32'h1999, 32'h999, 1);
    tick();
    chk_out("drop17", 1, 32'h1000, 32'h0, 1);

    // Full with simultaneous push and pop
    drive(1, 0, 1, 32'h1010, 32'h40, 0);
    tick();
    chk_out("fullpp", 1, 32'h1001, 32'h4, 1);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d.pc", k), 64'(decoder_pc_out), 64'(4*(k+1)));
      tick();
    end
    chk_out("drained", 0, 0, 0, 0);

    // Pointer wrap: 3 entries resident while 40 push/pop pairs stream through
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 1, 32'h3000 + 4*j ^ 32'hA5A50000, 32'h3000 + 4*j, 1);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 1, 32'h3000 + 4*(i+3) ^ 32'hA5A50000, 32'h3000 + 4*(i+3), 0);
      tick();
      chk($sformatf("wrap%0d.pc", i), 64'(decoder_pc_out), 64'(32'h3000 + 4*(i+1)));
      chk($sformatf("wrap%0d.inst", i), 64'(decoder_inst_out),
          64'(32'h3000 + 4*(i+1) ^ 32'hA5A50000));
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("wtail%0d.pc", j), 64'(decoder_pc_out), 64'(32'h3000 + 4*(40+j)));
      tick();
    end
    chk_out("wrap_end", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
